// File: rtl/mem_stage_arbiter.sv
// Arbitrates the single-port data memory between the CPU Memory stage and the audio DMA engine.
// Hides the fixed memory latency and holds the pipeline via StallM while a CPU access is pending.
//
// state    | meaning
// IDLE     | memory free, arbitrate between CPU and DMA
// CPU_ACC  | CPU access in flight, beat counter 0..LAT-1
// CPU_DONE | CPU load data valid, pipeline released for one cycle
// DMA_ACC  | DMA access in flight, dma_gnt high
// DMA_DONE | dma_done pulse, DMA read data valid
module mem_stage_arbiter #(
   parameter int bits         = 32,
   parameter int LAT          = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MemReqM,
   input  logic            MemWriteM,
   input  logic [bits-1:0] ALUResultM,
   input  logic [bits-1:0] WriteDataM,
   output logic [bits-1:0] ReadDataM,
   output logic            StallM,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [bits-1:0] dma_addr,
   input  logic [bits-1:0] dma_wdata,
   output logic            dma_gnt,
   output logic [bits-1:0] dma_rdata,
   output logic            dma_done,
   output logic            mem_en,
   output logic            mem_we,
   output logic [bits-1:0] mem_addr,
   output logic [bits-1:0] mem_wdata,
   input  logic [bits-1:0] mem_rdata
);

   localparam int BW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(LAT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CPU_ACC  = 3'd1,
      S_CPU_DONE = 3'd2,
      S_DMA_ACC  = 3'd3,
      S_DMA_DONE = 3'd4
   } state_t;

   state_t            state_q;
   logic [BW-1:0]     beat_q;
   logic [SW-1:0]     starve_q;
   logic [bits-1:0]   cpu_rdata_q;
   logic [bits-1:0]   dma_rdata_q;
   logic              dma_gnt_q;
   logic              dma_done_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [bits-1:0]   mem_addr_q;
   logic [bits-1:0]   mem_wdata_q;
   logic              dma_active;
   logic              dma_first;

   assign dma_active = (state_q == S_DMA_ACC) || (state_q == S_DMA_DONE);
   // A starved DMA request outranks the CPU; otherwise the CPU goes first.
   assign dma_first  = dma_req && (starve_q == STARVE_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         dma_gnt_q   <= 1'b0;
         dma_done_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         dma_done_q <= 1'b0;

         if (!dma_req) begin
            starve_q <= '0;
         end else if (!dma_active && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + SW'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (dma_first || (dma_req && !MemReqM)) begin
                  state_q     <= S_DMA_ACC;
                  beat_q      <= '0;
                  starve_q    <= '0;
                  dma_gnt_q   <= 1'b1;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= dma_we;
                  mem_addr_q  <= dma_addr;
                  mem_wdata_q <= dma_wdata;
               end else if (MemReqM) begin
                  state_q     <= S_CPU_ACC;
                  beat_q      <= '0;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= MemWriteM;
                  mem_addr_q  <= ALUResultM;
                  mem_wdata_q <= WriteDataM;
               end
            end

            S_CPU_ACC: begin
               if (beat_q == BEAT_LAST) begin
                  if (!mem_we_q) begin
                     cpu_rdata_q <= mem_rdata;
                  end
                  state_q     <= S_CPU_DONE;
                  beat_q      <= '0;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end else begin
                  beat_q <= beat_q + BW'(1);
               end
            end

            // No arbitration here so the request just served is not re-issued.
            S_CPU_DONE: state_q <= S_IDLE;

            S_DMA_ACC: begin
               if (beat_q == BEAT_LAST) begin
                  if (!mem_we_q) begin
                     dma_rdata_q <= mem_rdata;
                  end
                  state_q     <= S_DMA_DONE;
                  beat_q      <= '0;
                  dma_gnt_q   <= 1'b0;
                  dma_done_q  <= 1'b1;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end else begin
                  beat_q <= beat_q + BW'(1);
               end
            end

            S_DMA_DONE: state_q <= S_IDLE;

            default: begin
               state_q   <= S_IDLE;
               beat_q    <= '0;
               dma_gnt_q <= 1'b0;
               mem_en_q  <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign StallM    = rst & MemReqM & (state_q != S_CPU_DONE);
   assign ReadDataM = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_gnt   = dma_gnt_q;
   assign dma_done  = dma_done_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_arbiter.sv
// Directed bench for mem_stage_arbiter: CPU load/store, DMA read, contention, starvation, reset abort.
module tb_mem_stage_arbiter;

   logic        clk;
   logic        rst;
   logic        MemReqM;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic [31:0] dma_rdata;
   logic        dma_done;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int tests;
   int failed;
   int cnt;

   mem_stage_arbiter #(.bits(32), .LAT(2), .STARVE_LIMIT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .MemReqM    (MemReqM),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_done   (dma_done),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests      = 0;
      failed     = 0;
      rst        = 1'b0;
      MemReqM    = 1'b0;
      MemWriteM  = 1'b0;
      ALUResultM = '0;
      WriteDataM = '0;
      dma_req    = 1'b0;
      dma_we     = 1'b0;
      dma_addr   = '0;
      dma_wdata  = '0;
      mem_rdata  = '0;

      #12;
      chk("rst_mem_en",  32'(mem_en), 32'd0);
      chk("rst_stall",   32'(StallM), 32'd0);
      chk("rst_gnt",     32'(dma_gnt), 32'd0);
      chk("rst_rdata",   ReadDataM, 32'd0);
      chk("rst_dmardata", dma_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // CPU load
      MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h10; mem_rdata = 32'hCAFE0001;
      #0;
      chk("t1_idle_stall", 32'(StallM), 32'd1);
      chk("t1_idle_en",    32'(mem_en), 32'd0);
      tick();
      chk("t1_b0_en",    32'(mem_en), 32'd1);
      chk("t1_b0_addr",  mem_addr, 32'h10);
      chk("t1_b0_we",    32'(mem_we), 32'd0);
      chk("t1_b0_stall", 32'(StallM), 32'd1);
      tick();
      chk("t1_b1_en",    32'(mem_en), 32'd1);
      chk("t1_b1_stall", 32'(StallM), 32'd1);
      tick();
      chk("t1_done_rdata", ReadDataM, 32'hCAFE0001);
      chk("t1_done_stall", 32'(StallM), 32'd0);
      chk("t1_done_en",    32'(mem_en), 32'd0);
      MemReqM = 1'b0;
      tick();
      chk("t1_idle2_en", 32'(mem_en), 32'd0);

      // CPU store
      MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h20; WriteDataM = 32'h55;
      mem_rdata = 32'hDEADBEEF;
      tick();
      chk("t2_b0_we",    32'(mem_we), 32'd1);
      chk("t2_b0_addr",  mem_addr, 32'h20);
      chk("t2_b0_wdata", mem_wdata, 32'h55);
      tick();
      chk("t2_b1_we",    32'(mem_we), 32'd1);
      chk("t2_b1_wdata", mem_wdata, 32'h55);
      tick();
      chk("t2_rdata_kept", ReadDataM, 32'hCAFE0001);
      MemReqM = 1'b0; MemWriteM = 1'b0;
      tick();

      // DMA read, CPU idle
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h400; mem_rdata = 32'h1234;
      tick();
      chk("t3_b0_gnt",  32'(dma_gnt), 32'd1);
      chk("t3_b0_addr", mem_addr, 32'h400);
      tick();
      chk("t3_b1_gnt",  32'(dma_gnt), 32'd1);
      chk("t3_b1_done", 32'(dma_done), 32'd0);
      tick();
      chk("t3_done",       32'(dma_done), 32'd1);
      chk("t3_done_gnt",   32'(dma_gnt), 32'd0);
      chk("t3_dma_rdata",  dma_rdata, 32'h1234);
      chk("t3_cpu_rdata",  ReadDataM, 32'hCAFE0001);
      dma_req = 1'b0;
      tick();
      chk("t3_done_pulse", 32'(dma_done), 32'd0);

      // CPU request arrives during DMA_ACC beat 0
      dma_req = 1'b1; dma_addr = 32'h404; mem_rdata = 32'h5678;
      tick();
      MemReqM = 1'b1; ALUResultM = 32'h30;
      #0;
      chk("t4_gnt", 32'(dma_gnt), 32'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!StallM) break;
         cnt++;
         if (dma_done) dma_req = 1'b0;
         tick();
      end
      chk("t4_stall_cycles", cnt, 32'd6);
      chk("t4_cpu_rdata", ReadDataM, 32'h5678);
      chk("t4_dma_rdata", dma_rdata, 32'h5678);
      MemReqM = 1'b0;
      tick();

      // Starvation: CPU keeps requesting, DMA wins at the third IDLE
      MemReqM = 1'b1; ALUResultM = 32'h30; dma_req = 1'b1; dma_addr = 32'h500;
      mem_rdata = 32'h77;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (dma_gnt) break;
         cnt++;
         tick();
      end
      chk("t5_grant_cycle", cnt, 32'd9);
      chk("t5_addr",  mem_addr, 32'h500);
      chk("t5_stall", 32'(StallM), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (dma_done) break;
         tick();
      end
      chk("t5_done", 32'(dma_done), 32'd1);
      chk("t5_dma_rdata", dma_rdata, 32'h77);
      tick();
      tick();
      chk("t5_cpu_wins_gnt",  32'(dma_gnt), 32'd0);
      chk("t5_cpu_wins_addr", mem_addr, 32'h30);
      MemReqM = 1'b0; dma_req = 1'b0;
      tick(); tick(); tick();

      // Reset during CPU_ACC beat 0
      MemReqM = 1'b1; ALUResultM = 32'h40; mem_rdata = 32'h99;
      tick();
      chk("t6_b0_en", 32'(mem_en), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_en",    32'(mem_en), 32'd0);
      chk("t6_rst_stall", 32'(StallM), 32'd0);
      chk("t6_rst_gnt",   32'(dma_gnt), 32'd0);
      chk("t6_rst_rdata", ReadDataM, 32'd0);
      MemReqM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("t6_post_en",    32'(mem_en), 32'd0);
      chk("t6_post_rdata", ReadDataM, 32'd0);
      MemReqM = 1'b1; ALUResultM = 32'h44;
      #0;
      chk("t6_post_stall", 32'(StallM), 32'd1);
      tick();
      chk("t6_new_addr", mem_addr, 32'h44);
      MemReqM = 1'b0;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
